mdr_divider: RTL and testbench

//  Sequential unsigned restoring divider for the MDR datapath; the inverse of the multiply path.

---
 rtl/mdr_pkg.sv | 10 +
 rtl/mdr_divider_if.sv | 24 ++
 rtl/mdr_subtractor.sv | 13 +
 rtl/mdr_divider.sv | 116 +++++++++++
 tb/tb_mdr_divider.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mdr_pkg.sv
// Shared MDR datapath constants and types.
// DW is also the width of data_bus_n elsewhere in the datapath.
package mdr_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = $clog2(DW);

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

endpackage

// File: rtl/mdr_divider_if.sv
// Start/done handshake and operand/result bundle between the MDR controller and the divider.
interface mdr_divider_if;
  import mdr_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/mdr_subtractor.sv
// Unsigned subtractor with borrow out, used for the divider's trial subtraction.
module mdr_subtractor #(
  parameter int unsigned W = mdr_pkg::DW + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/mdr_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// A zero divisor skips the iteration and reports quotient='1, remainder=dividend.
module mdr_divider
  import mdr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mdr_divider_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    q_q;
  logic [DW-1:0]    r_q;
  logic [DW-1:0]    d_q;
  logic [DW-1:0]    quotient_q;
  logic [DW-1:0]    remainder_q;
  logic             div_zero_q;
  logic             done_q;

  logic [DW:0]      r_shift;
  logic [DW:0]      trial;
  logic             borrow;
  logic [DW-1:0]    q_step;
  logic [DW-1:0]    r_step;
  logic             unused_msb;

  mdr_subtractor #(
    .W (DW + 1)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, d_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // After a successful trial the remainder is below the divisor, so the top bit is always 0.
  assign unused_msb = trial[DW];

  always_comb begin
    state_d = state_q;
    r_shift = {r_q, q_q[DW-1]};
    q_step  = {q_q[DW-2:0], ~borrow};
    r_step  = borrow ? r_shift[DW-1:0] : trial[DW-1:0];

    case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          state_d = (bus.divisor == '0) ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (bus.start) begin
            d_q        <= bus.divisor;
            div_zero_q <= 1'b0;
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              div_zero_q  <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              q_q   <= bus.dividend;
              r_q   <= '0;
              cnt_q <= CNT_W'(DW - 1);
            end
          end
        end
        DIV_CALC: begin
          q_q <= q_step;
          r_q <= r_step;
          // Results are published on entry to DONE so done and data appear together.
          if (cnt_q == '0) begin
            quotient_q  <= q_step;
            remainder_q <= r_step;
            done_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state_q == DIV_IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_mdr_divider.sv
// Bench for mdr_divider: directed vector table, hand-written corner sequences, random operands.
module tb_mdr_divider;
  import mdr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mdr_divider_if bus ();

  mdr_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one start at the next cycle (cycle 0) and returns at the negedge of the cycle in
  // which done is first seen; lat is that cycle number, or -1 if done never came.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit noise,
                        output int lat);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (noise && c >= 3 && c <= 10) begin
        bus.start    = 1'b1;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    int          lat;
    logic [15:0] a, b;
    logic [31:0] eq, er;
    int          mode;

    vecs[0] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2,    z: 1'b0, lat: 17};
    vecs[1] = '{a: 16'hFFFF,   b: 16'd1,      q: 16'hFFFF,   r: 16'd0,    z: 1'b0, lat: 17};
    vecs[2] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'd1,      r: 16'd0,    z: 1'b0, lat: 17};
    vecs[3] = '{a: 16'd5,      b: 16'd9,      q: 16'd0,      r: 16'd5,    z: 1'b0, lat: 17};
    vecs[4] = '{a: 16'd0,      b: 16'd3,      q: 16'd0,      r: 16'd0,    z: 1'b0, lat: 17};
    vecs[5] = '{a: 16'd1234,   b: 16'd0,      q: 16'hFFFF,   r: 16'd1234, z: 1'b1, lat: 1};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_quotient", 32'(bus.quotient), 32'd0);
    chk("reset_remainder", 32'(bus.remainder), 32'd0);
    chk("reset_div_zero", 32'(bus.div_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Consecutive entries run back-to-back: each start lands the cycle after the previous done.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_quotient", i), 32'(bus.quotient), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(bus.remainder), 32'(vecs[i].r));
      chk($sformatf("vec%0d_div_zero", i), 32'(bus.div_zero), 32'(vecs[i].z));
      chk($sformatf("vec%0d_ready_in_done", i), 32'(bus.ready), 32'd0);
    end

    // Starts during CALC must be ignored, and exactly one done must follow.
    run_op(16'd100, 16'd7, 1'b1, lat);
    chk("busy_latency", 32'(lat), 32'd17);
    chk("busy_quotient", 32'(bus.quotient), 32'd14);
    chk("busy_remainder", 32'(bus.remainder), 32'd2);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("busy_no_extra_done%0d", c), 32'(bus.done), 32'd0);
    end

    run_op(16'd1234, 16'd0, 1'b0, lat);
    chk("zero_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_ready_cycle2", 32'(bus.ready), 32'd1);
    chk("zero_held_quotient", 32'(bus.quotient), 32'hFFFF);
    chk("zero_held_div_zero", 32'(bus.div_zero), 32'd1);

    // Reset in cycle 5 of 500/3 discards the partial result.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 16'd500;
    bus.divisor  = 16'd3;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    chk("midrst_div_zero", 32'(bus.div_zero), 32'd0);
    run_op(16'd500, 16'd3, 1'b0, lat);
    chk("after_rst_latency", 32'(lat), 32'd17);
    chk("after_rst_quotient", 32'(bus.quotient), 32'd166);
    chk("after_rst_remainder", 32'(bus.remainder), 32'd2);

    for (int n = 0; n < 2000; n++) begin
      a    = 16'($urandom);
      mode = int'($urandom_range(0, 9));
      if (mode == 0)      b = 16'd0;
      else if (mode <= 3) b = 16'($urandom_range(1, 15));
      else                b = 16'($urandom);
      if (b == 0) begin
        eq = 32'hFFFF;
        er = 32'(a);
      end else begin
        eq = 32'(a) / 32'(b);
        er = 32'(a) % 32'(b);
      end
      run_op(a, b, 1'b0, lat);
      chk($sformatf("rnd%0d_latency %0d/%0d", n, a, b), 32'(lat), (b == 0) ? 32'd1 : 32'd17);
      chk($sformatf("rnd%0d_quotient %0d/%0d", n, a, b), 32'(bus.quotient), eq);
      chk($sformatf("rnd%0d_remainder %0d/%0d", n, a, b), 32'(bus.remainder), er);
      chk($sformatf("rnd%0d_div_zero %0d/%0d", n, a, b), 32'(bus.div_zero), 32'(b == 0));
      if (b != 0) begin
        chk($sformatf("rnd%0d_invariant %0d/%0d", n, a, b),
            32'((32'(bus.quotient) * 32'(b) + 32'(bus.remainder) == 32'(a)) &&
                (bus.remainder < b)), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
